// File: rtl/crypto_arb_pkg.sv
// Shared definitions for the crypto packet arbiter slice:
// FSM state encodings, port indices and the data-word ctrl value.
package crypto_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      BODY = 2'd2
   } arb_state_t;

   localparam logic PORT_ENC = 1'b0;
   localparam logic PORT_DEC = 1'b1;

   // ctrl value of a plain data word; anything else is
   // a module header (before BODY) or the EOP marker (in BODY)
   localparam int CTRL_DATA = 0;

endpackage

// File: rtl/crypto_rr_pick.sv
// Two-way packet-level pick with a last_grant register (resets to port 1).
// Ports: clk, reset, req[1:0], upd/upd_port (record a finished grant), pick.
// CRYPTO_ARB_STRICT_PRIO_EN: port 0 always wins when requesting.
module crypto_rr_pick
   import crypto_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       upd,
   input  logic       upd_port,
   output logic       pick
);

   logic last_grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    last_grant <= PORT_DEC;
      else if (upd) last_grant <= upd_port;
   end

`ifdef CRYPTO_ARB_STRICT_PRIO_EN
   assign pick = req[PORT_ENC] ? PORT_ENC : PORT_DEC;
`else
   always_comb begin
      pick = req[PORT_DEC];
      if (req == 2'b11) pick = ~last_grant;
   end
`endif

endmodule

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: dout always shows the head word.
// Ports: clk, reset (async, high), din/wr_en, rd_en, dout, empty, nearly_full.
module fallthrough_small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             nearly_full
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;

   logic [WIDTH-1:0]          mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr;
   logic [MAX_DEPTH_BITS:0]   cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         cnt <= cnt + (MAX_DEPTH_BITS+1)'(wr_en)
                    - (MAX_DEPTH_BITS+1)'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   assign dout        = mem[rd_ptr];
   assign empty       = (cnt == '0);
   // one slot of slack so a writer seeing rdy may always write once
   assign nearly_full = (cnt >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));

endmodule

// File: rtl/crypto_pkt_arbiter.sv
// Shares one crypto engine between the encrypt (0) and decrypt (1) streams,
// packet-granular round robin. Ports: inN_* inputs, out_* engine stream,
// key_sel/busy status, pkt_cnt0/1. Macro: CRYPTO_ARB_STRICT_PRIO_EN.
module crypto_pkt_arbiter
   import crypto_arb_pkg::*;
#(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH/8,
   parameter int FIFO_DEPTH_BITS = 2,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in0_data,
   input  logic [CTRL_WIDTH-1:0] in0_ctrl,
   input  logic                  in0_wr,
   output logic                  in0_rdy,
   input  logic [DATA_WIDTH-1:0] in1_data,
   input  logic [CTRL_WIDTH-1:0] in1_ctrl,
   input  logic                  in1_wr,
   output logic                  in1_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   output logic                  key_sel,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  pkt_cnt0,
   output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

   localparam int W = CTRL_WIDTH + DATA_WIDTH;
   localparam logic [CTRL_WIDTH-1:0] CTRL_D = CTRL_WIDTH'(CTRL_DATA);

   arb_state_t state, state_nxt;
   logic       grant, grant_nxt, pick;
   logic       rd_en, eop, head_empty;
   logic [1:0] f_empty, f_nf, f_rd;
   logic [W-1:0] f0_dout, f1_dout, head;

   fallthrough_small_fifo #(
      .WIDTH(W), .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)
   ) u_fifo0 (
      .clk(clk), .reset(reset),
      .din({in0_ctrl, in0_data}), .wr_en(in0_wr),
      .rd_en(f_rd[0]), .dout(f0_dout),
      .empty(f_empty[0]), .nearly_full(f_nf[0])
   );

   fallthrough_small_fifo #(
      .WIDTH(W), .MAX_DEPTH_BITS(FIFO_DEPTH_BITS)
   ) u_fifo1 (
      .clk(clk), .reset(reset),
      .din({in1_ctrl, in1_data}), .wr_en(in1_wr),
      .rd_en(f_rd[1]), .dout(f1_dout),
      .empty(f_empty[1]), .nearly_full(f_nf[1])
   );

   crypto_rr_pick u_pick (
      .clk(clk), .reset(reset),
      .req(~f_empty), .upd(eop), .upd_port(grant),
      .pick(pick)
   );

   assign in0_rdy    = ~f_nf[0];
   assign in1_rdy    = ~f_nf[1];
   assign head       = grant ? f1_dout : f0_dout;
   assign head_empty = grant ? f_empty[1] : f_empty[0];
   assign f_rd[0]    = rd_en & (grant == PORT_ENC);
   assign f_rd[1]    = rd_en & (grant == PORT_DEC);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      rd_en     = 1'b0;
      eop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (~&f_empty) begin
               state_nxt = HDR;
               grant_nxt = pick;
            end
         end
         HDR: begin
            rd_en = ~head_empty & out_rdy;
            if (rd_en && head[W-1 -: CTRL_WIDTH] == CTRL_D)
               state_nxt = BODY;
         end
         BODY: begin
            rd_en = ~head_empty & out_rdy;
            if (rd_en && head[W-1 -: CTRL_WIDTH] != CTRL_D) begin
               eop       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= PORT_ENC;
         out_wr   <= 1'b0;
         out_data <= '0;
         out_ctrl <= '0;
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         out_wr <= rd_en;
         if (rd_en) {out_ctrl, out_data} <= head;
         if (eop && grant == PORT_ENC)
            pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
         if (eop && grant == PORT_DEC)
            pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
      end
   end

   assign key_sel = grant;
   // covers the EOP word's write cycle after the FSM is back in IDLE
   assign busy    = (state != IDLE) | out_wr;

endmodule

// File: tb/tb_crypto_pkt_arbiter.sv
// Scoreboard bench for crypto_pkt_arbiter: per-port word queues and an
// expected packet-owner queue, popped as words leave the arbiter.
module tb_crypto_pkt_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] in0_data, in1_data, out_data;
   logic [7:0]  in0_ctrl, in1_ctrl, out_ctrl;
   logic        in0_wr, in1_wr, in0_rdy, in1_rdy;
   logic        out_wr, out_rdy, key_sel, busy;
   logic [15:0] pkt_cnt0, pkt_cnt1;

   int checks   = 0;
   int failures = 0;

   logic [71:0] q0[$];
   logic [71:0] q1[$];
   logic        ord[$];
   logic        in_pkt, in_hdr, prev_rdy;

   always #5 clk = ~clk;

   crypto_pkt_arbiter dut (
      .clk(clk), .reset(reset),
      .in0_data(in0_data), .in0_ctrl(in0_ctrl),
      .in0_wr(in0_wr), .in0_rdy(in0_rdy),
      .in1_data(in1_data), .in1_ctrl(in1_ctrl),
      .in1_wr(in1_wr), .in1_rdy(in1_rdy),
      .out_data(out_data), .out_ctrl(out_ctrl),
      .out_wr(out_wr), .out_rdy(out_rdy),
      .key_sel(key_sel), .busy(busy),
      .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
   );

   task automatic check(string tag, logic [71:0] got,
                        logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] mk_word(int p, int id,
                                           int i, int tot);
      logic [7:0] c;
      c = (i == 0) ? 8'hFF : (i == tot-1) ? 8'h40 : 8'h00;
      return {c, 8'(p), 8'(id), 48'(i)};
   endfunction

   task automatic drv(int p, logic wr, logic [71:0] w);
      if (p == 0) begin
         in0_wr = wr; {in0_ctrl, in0_data} = w;
      end else begin
         in1_wr = wr; {in1_ctrl, in1_data} = w;
      end
   endtask

   task automatic send_pkt(int p, int id, int n, int tot,
                           int gap_at, int gap);
      logic [71:0] w;
      int t;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == gap_at) begin
            drv(p, 1'b0, '0);
            repeat (gap) @(negedge clk);
         end
         t = 0;
         while (!(p == 0 ? in0_rdy : in1_rdy)) begin
            drv(p, 1'b0, '0);
            @(negedge clk);
            t++;
            if (t > 500) begin
               check("rdy_timeout", 0, 1);
               return;
            end
         end
         w = mk_word(p, id, i, tot);
         drv(p, 1'b1, w);
         if (p == 0) q0.push_back(w);
         else        q1.push_back(w);
      end
   endtask

   task automatic rel(int p);
      @(negedge clk);
      drv(p, 1'b0, '0);
   endtask

   task automatic wait_drain(int lim);
      int t = 0;
      while ((q0.size() != 0 || q1.size() != 0 ||
              ord.size() != 0 || busy) && t < lim) begin
         @(negedge clk);
         t++;
      end
      check("drain", t < lim, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [71:0] exp;
      logic        e;
      #1;
      if (reset) begin
         in_pkt = 1'b0;
         in_hdr = 1'b1;
      end else if (out_wr) begin
         check("wr_after_rdy", prev_rdy, 1);
         check("busy_wr", busy, 1);
         if (!in_pkt) begin
            in_pkt = 1'b1;
            in_hdr = 1'b1;
            if (ord.size() != 0) begin
               e = ord.pop_front();
               check("pkt_owner", key_sel, e);
            end else begin
               check("extra_pkt", 1, 0);
            end
         end
         if ((key_sel ? q1.size() : q0.size()) == 0) begin
            check("unexpected_word", {out_ctrl, out_data}, 0);
         end else begin
            exp = key_sel ? q1.pop_front() : q0.pop_front();
            check("word", {out_ctrl, out_data}, exp);
         end
         if (in_hdr) begin
            if (out_ctrl == 8'h00) in_hdr = 1'b0;
         end else if (out_ctrl != 8'h00) begin
            in_pkt = 1'b0;
         end
      end
      prev_rdy = out_rdy;
   end

   initial begin
      #300000;
      failures++;
      $display("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

   initial begin
      reset    = 1'b1;
      drv(0, 1'b0, '0);
      drv(1, 1'b0, '0);
      out_rdy  = 1'b1;
      prev_rdy = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_wr", out_wr, 0);
      check("rst_busy", busy, 0);
      check("rst_key_sel", key_sel, 0);
      check("rst_cnt0", pkt_cnt0, 0);
      check("rst_cnt1", pkt_cnt1, 0);
      check("rst_rdy0", in0_rdy, 1);
      @(negedge clk);
      reset = 1'b0;

      // single 8-word encrypt packet
      ord.push_back(1'b0);
      send_pkt(0, 1, 8, 8, 99, 0);
      rel(0);
      wait_drain(300);
      check("t1_cnt0", pkt_cnt0, 1);
      check("t1_cnt1", pkt_cnt1, 0);
      check("t1_busy", busy, 0);

      // both ports load together: port 0 first
      do_reset();
      ord.push_back(1'b0);
      ord.push_back(1'b1);
      fork
         begin send_pkt(0, 2, 5, 5, 99, 0); rel(0); end
         begin send_pkt(1, 3, 5, 5, 99, 0); rel(1); end
      join
      wait_drain(300);
      check("t2_cnt0", pkt_cnt0, 1);
      check("t2_cnt1", pkt_cnt1, 1);

      // out_rdy toggling during a port 1 packet
      ord.push_back(1'b1);
      ord.push_back(1'b0);
      fork
         begin send_pkt(1, 4, 6, 6, 99, 0); rel(1); end
         begin
            repeat (4) @(negedge clk);
            send_pkt(0, 5, 5, 5, 99, 0);
            rel(0);
         end
         begin
            repeat (3) @(negedge clk);
            repeat (16) begin
               out_rdy = ~out_rdy;
               @(negedge clk);
            end
            out_rdy = 1'b1;
         end
      join
      wait_drain(300);
      check("t3_cnt0", pkt_cnt0, 2);
      check("t3_cnt1", pkt_cnt1, 2);

      // port 0 runs dry mid-body, port 1 must wait
      ord.push_back(1'b0);
      ord.push_back(1'b1);
      fork
         begin send_pkt(0, 6, 8, 8, 3, 10); rel(0); end
         begin
            repeat (3) @(negedge clk);
            send_pkt(1, 7, 5, 5, 99, 0);
            rel(1);
         end
      join
      wait_drain(300);
      check("t4_cnt0", pkt_cnt0, 3);
      check("t4_cnt1", pkt_cnt1, 3);

      // reset mid-BODY with the EOP-less packet still queued
      out_rdy = 1'b0;
      ord.push_back(1'b0);
      send_pkt(0, 8, 3, 8, 99, 0);
      rel(0);
      out_rdy = 1'b1;
      repeat (2) @(negedge clk);
      out_rdy = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("t5_out_wr", out_wr, 0);
      check("t5_busy", busy, 0);
      check("t5_key_sel", key_sel, 0);
      check("t5_cnt0", pkt_cnt0, 0);
      check("t5_cnt1", pkt_cnt1, 0);
      check("t5_rdy0", in0_rdy, 1);
      q0.delete();
      ord.delete();
      @(negedge clk);
      reset   = 1'b0;
      out_rdy = 1'b1;
      repeat (10) @(negedge clk);
      check("t5_idle_busy", busy, 0);
      ord.push_back(1'b1);
      send_pkt(1, 9, 5, 5, 99, 0);
      rel(1);
      wait_drain(300);
      check("t5_cnt1_new", pkt_cnt1, 1);
      check("t5_cnt0_new", pkt_cnt0, 0);

      // three port 0 packets against one port 1 packet
`ifdef CRYPTO_ARB_STRICT_PRIO_EN
      ord.push_back(1'b0);
      ord.push_back(1'b0);
      ord.push_back(1'b0);
      ord.push_back(1'b1);
`else
      ord.push_back(1'b0);
      ord.push_back(1'b1);
      ord.push_back(1'b0);
      ord.push_back(1'b0);
`endif
      fork
         begin
            send_pkt(0, 10, 5, 5, 99, 0);
            send_pkt(0, 11, 5, 5, 99, 0);
            send_pkt(0, 12, 5, 5, 99, 0);
            rel(0);
         end
         begin send_pkt(1, 13, 5, 5, 99, 0); rel(1); end
      join
      wait_drain(600);
      check("t6_cnt0", pkt_cnt0, 3);
      check("t6_cnt1", pkt_cnt1, 2);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/crypto_pkt_arbiter.md
Name: crypto_pkt_arbiter

Overview:
- Shares one crypto datapath between two packet requesters: port 0 is the encrypt-direction stream, port 1 the decrypt-direction stream.
- Buffers each input in a small fallthrough FIFO and grants the engine at packet granularity, round-robin.
- Never interleaves words of two packets.
- Presents a single NetFPGA data/ctrl/wr/rdy stream to the crypto block, plus a per-packet key-select.

Parameters:
- DATA_WIDTH, 64, datapath width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
- FIFO_DEPTH_BITS, 2, log2 of per-input FIFO depth.
- CNT_WIDTH, 16, width of per-port packet counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in0_data  in  DATA_WIDTH  port 0 data.
- in0_ctrl  in  CTRL_WIDTH  port 0 ctrl.
- in0_wr  in  1  port 0 write strobe.
- in0_rdy  out  1  port 0 may write.
- in1_data  in  DATA_WIDTH  port 1 data.
- in1_ctrl  in  CTRL_WIDTH  port 1 ctrl.
- in1_wr  in  1  port 1 write strobe.
- in1_rdy  out  1  port 1 may write.
- out_data  out  DATA_WIDTH  to crypto engine.
- out_ctrl  out  CTRL_WIDTH  to crypto engine.
- out_wr  out  1  output write strobe.
- out_rdy  in  1  engine can accept a word.
- key_sel  out  1  owner of the packet in flight (0 = encrypt key, 1 = decrypt key).
- busy  out  1  a packet is in flight.
- pkt_cnt0  out  CNT_WIDTH  packets forwarded from port 0.
- pkt_cnt1  out  CNT_WIDTH  packets forwarded from port 1.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; last_grant = 1, so port 0 wins first.
  - FIFOs flushed.
  - Asserting reset mid-packet truncates the packet; the engine's own reset recovers it.
- inN_rdy = !fifoN_nearly_full. Writes while not rdy are a protocol error; FIFO behaviour is undefined.
- Output words are registered: 1 cycle from FIFO read to out_wr.
  - A FIFO word is read only when that port is granted, its FIFO is non-empty and out_rdy = 1.
  - out_wr follows the read by one cycle. The engine's out_rdy slack covers this.
- IDLE:
  - Requesters are the non-empty FIFOs.
  - Both requesting → grant !last_grant. One requesting → grant it.
  - On grant: go to HDR, set grant, key_sel = grant, busy = 1.
  - No read occurs in the IDLE cycle.
- HDR:
  - Forward words while ctrl != 0 (module headers).
  - Forwarding the first word with ctrl == 0 → go to BODY.
- BODY:
  - Forward words.
  - Forwarding a word with ctrl != 0 is EOP: go to IDLE, last_grant = grant, pkt_cntN += 1 (wraps at 2^CNT_WIDTH), busy drops the cycle after the EOP word is written.
- Packet spacing:
  - Minimum 1 idle cycle between packets (the IDLE decision).
  - Back-to-back requests alternate ports: 0, 1, 0, 1.
- Stalls:
  - out_rdy low stalls reads; grant and state are held.
  - An empty FIFO mid-packet stalls the packet; the other port is never granted mid-packet.
- key_sel and grant are stable from the grant decision through the EOP word's out_wr cycle.
- Simultaneous: EOP on the granted port while the other port is empty and the same port has a new packet queued → the same port is re-granted after IDLE.

Optional Feature:
- Macro CRYPTO_ARB_STRICT_PRIO_EN.
- Defined: IDLE always grants port 0 when it is non-empty; last_grant is ignored. Port 1 can starve.
- Undefined: round-robin as described above.

Decomposition:
- Shared package (crypto_arb_pkg): state encodings IDLE/HDR/BODY, port index constants PORT_ENC=0 and PORT_DEC=1, and the EOP/header ctrl test constant (CTRL_DATA = 0).
- Sub-module: the existing fallthrough_small_fifo, instantiated twice.
- Optional sub-module: crypto_rr_pick, a 2-way round-robin decision with last_grant register. It is small and reused by the strict-priority variant.

Test Plan:
- Single packet on port 0 (ctrl words FF, 00×6, 40 EOP), out_rdy = 1 → 8 words out in order, key_sel = 0, pkt_cnt0 = 1, busy high through the EOP write.
- Both ports load a 5-word packet in the same cycle → port 0's packet fully, one idle cycle, then port 1's. key_sel 0 then 1. Counters 1/1. No interleave.
- out_rdy toggles 1,0,1,0 during a port 1 packet → out_wr only in the cycles after an out_rdy = 1 read. Data is intact. Port 0 is not granted until after port 1's EOP.
- Port 0 FIFO runs empty mid-body while port 1 has data → output pauses. Port 1 is not granted until port 0's EOP is forwarded.
- Reset asserted mid-BODY → all outputs 0 asynchronously, FIFOs empty. A fresh port 1 packet after release is forwarded with key_sel = 1.
- With CRYPTO_ARB_STRICT_PRIO_EN, three queued port 0 packets and one port 1 packet → order 0, 0, 0, 1. Without the macro → 0, 1, 0, 0.
